// File: rtl/mat_mult_seq.sv
// mat_mult_seq: index-driven sequencer for an NxN matrix multiply; issues A/B operand
// reads, MAC clear/enable strobes aligned to the read latency, and result writes.
module mat_mult_seq #(
  parameter int N      = 8,
  parameter int AW     = 6,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   cycle_count
);
  localparam int LW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  state_e state_q, state_d;
  logic [LW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [2:0]    dcnt_q, dcnt_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          first_q, last_q;
  logic [AW-1:0] oaddr_q;
  logic          v_q [RD_LAT];
  logic          c_q [RD_LAT];
  logic          w_q [RD_LAT];
  logic [AW-1:0] o_q [RD_LAT];
  assign mac_en      = v_q[RD_LAT-1];
  assign mac_clr     = c_q[RD_LAT-1];
  assign cycle_count = cnt_q;
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    cnt_d   = (state_q == RUN || state_q == DRAIN) ? cnt_q + 16'd1 : cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
        cnt_d   = '0;
      end
      RUN: begin
        k_d = k_q + 1'b1;
        j_d = &k_q ? j_q + 1'b1 : j_q;
        i_d = (&k_q && &j_q) ? i_q + 1'b1 : i_q;
        if (&{i_q, j_q, k_q}) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end
      end
      DRAIN: begin
        dcnt_d  = dcnt_q + 3'd1;
        state_d = (dcnt_q == 3'(RD_LAT)) ? DONE : DRAIN;
      end
      DONE:    state_d = start ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Outputs trail the state register by one stage; the tag pipe then adds RD_LAT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      dcnt_q  <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      addr_a  <= '0;
      addr_b  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      oaddr_q <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        v_q[s] <= 1'b0;
        c_q[s] <= 1'b0;
        w_q[s] <= 1'b0;
        o_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      dcnt_q  <= dcnt_d;
      cnt_q   <= cnt_d;
      busy    <= state_q == RUN || state_q == DRAIN;
      done    <= state_q == DONE;
      rd_en   <= state_q == RUN;
      addr_a  <= AW'({i_q, k_q});
      addr_b  <= AW'({k_q, j_q});
      first_q <= k_q == '0;
      last_q  <= &k_q;
      oaddr_q <= AW'({i_q, j_q});
      v_q[0]  <= rd_en;
      c_q[0]  <= rd_en & first_q;
      w_q[0]  <= rd_en & last_q;
      o_q[0]  <= oaddr_q;
      for (int s = 1; s < RD_LAT; s++) begin
        v_q[s] <= v_q[s-1];
        c_q[s] <= c_q[s-1];
        w_q[s] <= w_q[s-1];
        o_q[s] <= o_q[s-1];
      end
      wr_en   <= w_q[RD_LAT-1];
      wr_addr <= o_q[RD_LAT-1];
    end
  end
endmodule

// File: tb/tb_mat_mult_seq.sv
// tb_mat_mult_seq: directed scenarios for mat_mult_seq (N=8/RD_LAT=1 and N=4/RD_LAT=3).
module tb_mat_mult_seq;
  logic clk = 1'b0, reset = 1'b1, start_a = 1'b0, start_b = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int compared = 0, mismatched = 0;

  logic a_busy, a_done, a_rd, a_mac, a_clr, a_wr;
  logic [5:0] a_aa, a_ab, a_wa;
  logic [15:0] a_cc;
  mat_mult_seq #(.N(8), .AW(6), .RD_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(a_busy), .done(a_done),
    .rd_en(a_rd), .addr_a(a_aa), .addr_b(a_ab), .mac_en(a_mac), .mac_clr(a_clr),
    .wr_en(a_wr), .wr_addr(a_wa), .cycle_count(a_cc));

  logic b_busy, b_done, b_rd, b_mac, b_clr, b_wr;
  logic [3:0] b_aa, b_ab, b_wa;
  logic [15:0] b_cc;
  mat_mult_seq #(.N(4), .AW(4), .RD_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(b_busy), .done(b_done),
    .rd_en(b_rd), .addr_a(b_aa), .addr_b(b_ab), .mac_en(b_mac), .mac_clr(b_clr),
    .wr_en(b_wr), .wr_addr(b_wa), .cycle_count(b_cc));

  int an_rd, an_mac, an_clr, an_wr, a_first_wr, a_last_wr, a_addr_err, a_wr_err, a_clr_err, a_bd_err;
  logic [5:0] a11_a, a11_b;
  logic a_prev_k0;
  logic [8:0] m;
  always @(negedge clk) begin
    m = 9'(an_rd);
    if (a_rd) begin
      if (a_aa !== {m[8:6], m[2:0]} || a_ab !== {m[2:0], m[5:3]}) a_addr_err++;
      if (an_rd == 10) begin a11_a = a_aa; a11_b = a_ab; end
      an_rd++;
    end
    if (a_mac) an_mac++;
    if (a_clr) begin
      an_clr++;
      if (!a_mac || !a_prev_k0) a_clr_err++;
    end
    a_prev_k0 = a_rd && a_aa[2:0] == 3'd0;
    if (a_wr) begin
      if (an_wr == 0) a_first_wr = cyc;
      a_last_wr = cyc;
      if (a_wa !== 6'(an_wr)) a_wr_err++;
      an_wr++;
    end
    if (a_busy && a_done) a_bd_err++;
  end

  int bn_mac, bn_clr, bn_wr, b_first_mac, b_last_wr, b_wr_err;
  always @(negedge clk) begin
    if (b_mac) begin
      if (bn_mac == 0) b_first_mac = cyc;
      bn_mac++;
    end
    if (b_clr) bn_clr++;
    if (b_wr) begin
      b_last_wr = cyc;
      if (b_wa !== 4'(bn_wr)) b_wr_err++;
      bn_wr++;
    end
  end

  task automatic clear_a();
    an_rd = 0; an_mac = 0; an_clr = 0; an_wr = 0; a_first_wr = -1; a_last_wr = -1;
    a_addr_err = 0; a_wr_err = 0; a_clr_err = 0; a_bd_err = 0; a11_a = '0; a11_b = '0; a_prev_k0 = 1'b0;
  endtask

  task automatic wait_done_a(output int dt);
    dt = -1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if (a_done) begin dt = cyc; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if ({a_busy, a_done, a_rd, a_aa, a_ab, a_mac, a_clr, a_wr, a_wa, a_cc} !== '0) begin
      mismatched++; $display("FAIL reset_a outputs got %h want 0", {a_busy, a_done, a_rd, a_aa, a_ab, a_mac, a_clr, a_wr, a_wa, a_cc});
    end
    compared++;
    if ({b_busy, b_done, b_rd, b_aa, b_ab, b_mac, b_clr, b_wr, b_wa, b_cc} !== '0) begin
      mismatched++; $display("FAIL reset_b outputs got %h want 0", {b_busy, b_done, b_rd, b_aa, b_ab, b_mac, b_clr, b_wr, b_wa, b_cc});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_job(input string tag);
    int t, dt;
    clear_a();
    @(negedge clk); start_a = 1'b1; t = cyc + 1;
    @(negedge clk); start_a = 1'b0;
    wait_done_a(dt);
    compared++; if (an_rd !== 512) begin mismatched++; $display("FAIL %s rd_count got %0d want 512", tag, an_rd); end
    compared++; if (an_mac !== 512) begin mismatched++; $display("FAIL %s mac_count got %0d want 512", tag, an_mac); end
    compared++; if (an_clr !== 64) begin mismatched++; $display("FAIL %s clr_count got %0d want 64", tag, an_clr); end
    compared++; if (an_wr !== 64) begin mismatched++; $display("FAIL %s wr_count got %0d want 64", tag, an_wr); end
    compared++; if (a_first_wr !== t + 10) begin mismatched++; $display("FAIL %s first_wr got %0d want %0d", tag, a_first_wr, t + 10); end
    compared++; if (a_last_wr !== t + 514) begin mismatched++; $display("FAIL %s last_wr got %0d want %0d", tag, a_last_wr, t + 514); end
    compared++; if (a_wr_err !== 0) begin mismatched++; $display("FAIL %s wr_addr_order got %0d bad want 0", tag, a_wr_err); end
    compared++; if (a_addr_err !== 0) begin mismatched++; $display("FAIL %s rd_addr_seq got %0d bad want 0", tag, a_addr_err); end
    compared++; if (a11_a !== 6'd2) begin mismatched++; $display("FAIL %s addr_a_11th got %0d want 2", tag, a11_a); end
    compared++; if (a11_b !== 6'd17) begin mismatched++; $display("FAIL %s addr_b_11th got %0d want 17", tag, a11_b); end
    compared++; if (a_clr_err !== 0) begin mismatched++; $display("FAIL %s clr_align got %0d bad want 0", tag, a_clr_err); end
    compared++; if (dt !== t + 515) begin mismatched++; $display("FAIL %s done_time got %0d want %0d", tag, dt, t + 515); end
    compared++; if (a_cc !== 16'd514) begin mismatched++; $display("FAIL %s cycle_count got %0d want 514", tag, a_cc); end
    compared++; if (a_bd_err !== 0) begin mismatched++; $display("FAIL %s busy_done_overlap got %0d want 0", tag, a_bd_err); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_hold();
    int t, dt;
    clear_a();
    @(negedge clk); start_a = 1'b1; t = cyc + 1;
    wait_done_a(dt);
    compared++; if (dt !== t + 515) begin mismatched++; $display("FAIL hold done_time got %0d want %0d", dt, t + 515); end
    repeat (20) @(negedge clk); #1;
    compared++; if (a_done !== 1'b1) begin mismatched++; $display("FAIL hold done_held got %b want 1", a_done); end
    compared++; if (a_busy !== 1'b0) begin mismatched++; $display("FAIL hold busy got %b want 0", a_busy); end
    compared++; if (an_rd !== 512) begin mismatched++; $display("FAIL hold no_rerun rd_count got %0d want 512", an_rd); end
    compared++; if (a_cc !== 16'd514) begin mismatched++; $display("FAIL hold cycle_count got %0d want 514", a_cc); end
    start_a = 1'b0;
    repeat (2) @(negedge clk); #1;
    compared++; if (a_done !== 1'b0) begin mismatched++; $display("FAIL hold idle_done got %b want 0", a_done); end
    compared++; if (a_cc !== 16'd514) begin mismatched++; $display("FAIL hold idle_cycle_count got %0d want 514", a_cc); end
    test_job("restart");
  endtask

  task automatic test_reset_mid();
    int t, wr_before;
    clear_a();
    @(negedge clk); start_a = 1'b1; t = cyc + 1;
    @(negedge clk); start_a = 1'b0;
    while (cyc < t + 200) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    compared++;
    if ({a_busy, a_done, a_rd, a_aa, a_ab, a_mac, a_clr, a_wr, a_wa, a_cc} !== '0) begin
      mismatched++; $display("FAIL reset_mid outputs got %h want 0", {a_busy, a_done, a_rd, a_aa, a_ab, a_mac, a_clr, a_wr, a_wa, a_cc});
    end
    wr_before = an_wr;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk); #1;
    compared++; if (an_wr !== wr_before) begin mismatched++; $display("FAIL reset_mid wr_after got %0d want %0d", an_wr, wr_before); end
    compared++; if (a_busy !== 1'b0) begin mismatched++; $display("FAIL reset_mid busy got %b want 0", a_busy); end
    test_job("after_reset");
  endtask

  task automatic test_start_toggle();
    int t, dt;
    clear_a();
    dt = -1;
    @(negedge clk); start_a = 1'b1; t = cyc + 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if (a_done) begin dt = cyc; break; end
      start_a = ~start_a;
    end
    start_a = 1'b0;
    compared++; if (an_rd !== 512) begin mismatched++; $display("FAIL toggle rd_count got %0d want 512", an_rd); end
    compared++; if (an_clr !== 64) begin mismatched++; $display("FAIL toggle clr_count got %0d want 64", an_clr); end
    compared++; if (an_wr !== 64) begin mismatched++; $display("FAIL toggle wr_count got %0d want 64", an_wr); end
    compared++; if (a_addr_err !== 0) begin mismatched++; $display("FAIL toggle rd_addr_seq got %0d bad want 0", a_addr_err); end
    compared++; if (a_wr_err !== 0) begin mismatched++; $display("FAIL toggle wr_addr_order got %0d bad want 0", a_wr_err); end
    compared++; if (dt !== t + 515) begin mismatched++; $display("FAIL toggle done_time got %0d want %0d", dt, t + 515); end
    compared++; if (a_cc !== 16'd514) begin mismatched++; $display("FAIL toggle cycle_count got %0d want 514", a_cc); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_rdlat3();
    int t, dt;
    bn_mac = 0; bn_clr = 0; bn_wr = 0; b_first_mac = -1; b_last_wr = -1; b_wr_err = 0; dt = -1;
    @(negedge clk); start_b = 1'b1; t = cyc + 1;
    @(negedge clk); start_b = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk); #1;
      if (b_done) begin dt = cyc; break; end
    end
    compared++; if (b_first_mac !== t + 4) begin mismatched++; $display("FAIL lat3 first_mac got %0d want %0d", b_first_mac, t + 4); end
    compared++; if (bn_mac !== 64) begin mismatched++; $display("FAIL lat3 mac_count got %0d want 64", bn_mac); end
    compared++; if (bn_clr !== 16) begin mismatched++; $display("FAIL lat3 clr_count got %0d want 16", bn_clr); end
    compared++; if (bn_wr !== 16) begin mismatched++; $display("FAIL lat3 wr_count got %0d want 16", bn_wr); end
    compared++; if (b_wr_err !== 0) begin mismatched++; $display("FAIL lat3 wr_addr_order got %0d bad want 0", b_wr_err); end
    compared++; if (b_last_wr !== t + 68) begin mismatched++; $display("FAIL lat3 last_wr got %0d want %0d", b_last_wr, t + 68); end
    compared++; if (dt !== t + 69) begin mismatched++; $display("FAIL lat3 done_time got %0d want %0d", dt, t + 69); end
    compared++; if (b_cc !== 16'd68) begin mismatched++; $display("FAIL lat3 cycle_count got %0d want 68", b_cc); end
  endtask

  initial begin
    clear_a();
    test_reset();
    test_job("basic");
    test_hold();
    test_reset_mid();
    test_start_toggle();
    test_rdlat3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
